// File: rtl/lzy_key_pkg.sv
// lzy_key_pkg: shared types and helpers for the key latch.
// Holds the FSM state type, key count and priority helper.
package lzy_key_pkg;

    localparam int NKEYS = 8;

    typedef enum logic {
        IDLE,
        HELD
    } key_state_t;

    // Highest set index wins, matching the encoder's I7-first priority.
    function automatic logic [2:0] pri_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NKEYS; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lzy_key_latch_debounce.sv
// lzy_debounce_bit: one key's synchroniser and tick-based debouncer.
// Flags the cycle in which the debounced level qualifies as pressed.
module lzy_debounce_bit
    import lzy_key_pkg::*;
#(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    input  logic tick,
    output logic fall
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          s1;
    logic          s;
    logic          d;
    logic [CW-1:0] c;
    logic          qual;

    // A differing key qualifies on the tick that completes its run.
    assign qual = (s != d) && tick && (c == LAST);
    assign fall = qual && d;

    // Two-flop synchroniser; idle keys read as released.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s  <= 1'b1;
        end else begin
            s1 <= key_n;
            s  <= s1;
        end
    end

    // Count ticks of continuous disagreement; any agreement restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            d <= 1'b1;
            c <= '0;
        end else if (s == d) begin
            c <= '0;
        end else if (tick) begin
            if (c == LAST) begin
                d <= s;
                c <= '0;
            end else begin
                c <= c + CW'(1);
            end
        end
    end

endmodule

// File: rtl/lzy_key_latch.sv
// lzy_key_latch: debounced eight-key front end for the encoder path.
// Latches the last pressed key as a held active-low request.
module lzy_key_latch
    import lzy_key_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_n,
    input  logic       clr,
    output logic [7:0] I_n,
    output logic       EI,
    output logic       press,
    output logic [2:0] key_code
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

    logic [PW-1:0]    pcnt;
    logic             tick;
    logic [NKEYS-1:0] pe;
    logic [2:0]       cap_idx;
    key_state_t       state;

    assign tick    = (pcnt == PLAST);
    assign cap_idx = pri_idx(pe);
    assign EI      = (state != HELD);

    // Free-running prescaler producing one debounce tick per period.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        lzy_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .key_n(key_n[i]),
            .tick (tick),
            .fall (pe[i])
        );
    end

    // Hold state machine; clear outranks a same-cycle capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            I_n      <= 8'hFF;
            press    <= 1'b0;
            key_code <= 3'd0;
        end else begin
            press <= 1'b0;
            if (clr) begin
                state    <= IDLE;
                I_n      <= 8'hFF;
                key_code <= 3'd0;
            end else if (|pe) begin
                state    <= HELD;
                I_n      <= ~(8'd1 << cap_idx);
                press    <= 1'b1;
                key_code <= cap_idx;
            end
        end
    end

endmodule

// File: tb/tb_lzy_key_latch.sv
// tb_lzy_key_latch: directed and random checks of the key latch.
// A timestamp-based debounce model predicts every output cycle.
module tb_lzy_key_latch;

    localparam int DIV = 4;
    localparam int ST  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_n;
    logic       clr;
    logic [7:0] I_n;
    logic       EI;
    logic       press;
    logic [2:0] key_code;

    int n_tests = 0;
    int n_fail  = 0;
    int npress  = 0;

    lzy_key_latch #(
        .DIV         (DIV),
        .STABLE_TICKS(ST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_n   (key_n),
        .clr     (clr),
        .I_n     (I_n),
        .EI      (EI),
        .press   (press),
        .key_code(key_code)
    );

    always #5 clk = ~clk;

    // Reference model: cycle count since reset, global tick count,
    // and per-key start tick of the current disagreement run.
    bit [7:0] h1, h2, md, act;
    int       rstart[8];
    int       cyc, ntick;
    bit       mheld, mpress;
    int       midx;

    function automatic bit is_tick();
        return (cyc % DIV) == DIV - 1;
    endfunction

    function automatic bit pred_fall(int i);
        int run;
        run = act[i] ? (ntick - rstart[i] + 1) : 1;
        return (h2[i] != md[i]) && is_tick() && run == ST && h2[i] == 1'b0;
    endfunction

    function automatic int run_ticks(int i);
        return act[i] ? (ntick - rstart[i]) : 0;
    endfunction

    task automatic model_edge();
        bit [7:0] fall;
        bit       t;
        int       best;
        fall = '0;
        if (rst) begin
            h1 = 8'hFF; h2 = 8'hFF; md = 8'hFF; act = '0;
            cyc = 0; ntick = 0;
            mheld = 0; mpress = 0; midx = 0;
            return;
        end
        t = is_tick();
        for (int i = 0; i < 8; i++) begin
            if (h2[i] == md[i]) begin
                act[i] = 0;
            end else begin
                if (!act[i]) begin
                    act[i] = 1;
                    rstart[i] = ntick;
                end
                if (t && (ntick - rstart[i] + 1) == ST) begin
                    fall[i] = (h2[i] == 1'b0);
                    md[i] = h2[i];
                    act[i] = 0;
                end
            end
        end
        if (t) ntick++;
        best = -1;
        for (int i = 0; i < 8; i++) if (fall[i]) best = i;
        mpress = 0;
        if (clr) begin
            mheld = 0;
            midx = 0;
        end else if (best >= 0) begin
            mheld = 1;
            midx = best;
            mpress = 1;
        end
        h2 = h1;
        h1 = key_n;
        cyc++;
    endtask

    function automatic logic [7:0] exp_in();
        logic [7:0] one;
        one = 8'h01;
        return mheld ? ~(one << midx) : 8'hFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_I_n", 32'(I_n), 32'(exp_in()));
        chk("model_EI", 32'(EI), 32'(!mheld));
        chk("model_press", 32'(press), 32'(mpress));
        chk("model_code", 32'(key_code), mheld ? 32'(midx) : 32'd0);
        chk("onehot", 32'($countones(~I_n) <= 1), 32'd1);
        if (press === 1'b1) npress++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_I_n"}, 32'(I_n), 32'hFF);
        chk({tag, "_EI"}, 32'(EI), 32'd1);
        chk({tag, "_code"}, 32'(key_code), 32'd0);
    endtask

    // Wait for a capture pulse, bounded; returns cycles waited or -1.
    task automatic wait_press(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (press === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("press_seen", 32'(lat > 0), 32'd1);
    endtask

    initial begin
        int  lat, p0, dur;
        bit  hit;
        rst = 1'b1;
        clr = 1'b0;
        key_n = 8'h00;

        // Reset values, with all keys pressed during reset.
        for (int k = 0; k < 3; k++) begin
            step();
            chk_idle("rst");
            chk("rst_press", 32'(press), 32'd0);
        end
        rst = 1'b0;
        key_n = 8'hFF;
        step();
        chk_idle("post_rst");
        chk("post_rst_press", 32'(press), 32'd0);
        steps(5);

        // Single press of key 5.
        p0 = npress;
        key_n[5] = 1'b0;
        wait_press(20, lat);
        chk("k5_lat_ok", 32'(lat >= 11 && lat <= 15), 32'd1);
        chk("k5_I_n", 32'(I_n), 32'hDF);
        chk("k5_EI", 32'(EI), 32'd0);
        chk("k5_code", 32'(key_code), 32'd5);
        steps(3);
        chk("k5_one_pulse", 32'(npress - p0), 32'd1);
        key_n = 8'hFF;
        steps(20);
        chk("k5_release_I_n", 32'(I_n), 32'hDF);
        chk("k5_release_EI", 32'(EI), 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_idle("k5_clr");

        // Bounce on key 2 never qualifies.
        p0 = npress;
        for (int k = 0; k < 40; k++) begin
            key_n[2] = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        key_n = 8'hFF;
        steps(20);
        chk("bounce_press", 32'(npress - p0), 32'd0);
        chk_idle("bounce");

        // Keys 4 and 1 together: 4 wins, 1 never captured.
        key_n = 8'b1110_1101;
        wait_press(20, lat);
        chk("sim_code", 32'(key_code), 32'd4);
        chk("sim_I_n", 32'(I_n), 32'hEF);
        p0 = npress;
        steps(30);
        chk("sim_no_more", 32'(npress - p0), 32'd0);
        chk("sim_hold_I_n", 32'(I_n), 32'hEF);
        key_n = 8'hFF;
        steps(20);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_idle("sim_clr");

        // Key 3 captured, then key 0 replaces it, then clear.
        key_n[3] = 1'b0;
        wait_press(20, lat);
        chk("rep3_code", 32'(key_code), 32'd3);
        key_n[0] = 1'b0;
        wait_press(20, lat);
        chk("rep0_code", 32'(key_code), 32'd0);
        chk("rep0_I_n", 32'(I_n), 32'hFE);
        chk("rep0_EI", 32'(EI), 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_idle("rep_clr");
        key_n = 8'hFF;
        steps(20);
        chk_idle("rep_settle");

        // Clear in the very cycle key 6 qualifies.
        p0 = npress;
        key_n[6] = 1'b0;
        hit = 0;
        for (int k = 0; k < 25 && !hit; k++) begin
            if (pred_fall(6)) begin
                clr = 1'b1;
                hit = 1;
            end
            step();
            clr = 1'b0;
        end
        chk("k6_hit", 32'(hit), 32'd1);
        chk_idle("k6_conflict");
        steps(10);
        chk("k6_no_press", 32'(npress - p0), 32'd0);
        chk_idle("k6_later");
        key_n = 8'hFF;
        steps(20);

        // Reset after key 7 has counted two ticks; full requalify.
        key_n[7] = 1'b0;
        hit = 0;
        for (int k = 0; k < 25 && !hit; k++) begin
            step();
            if (run_ticks(7) == 2) hit = 1;
        end
        chk("k7_two_ticks", 32'(hit), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("k7_rst");
        wait_press(25, lat);
        chk("k7_requal", 32'(lat >= 11 && lat <= 15), 32'd1);
        chk("k7_code", 32'(key_code), 32'd7);
        chk("k7_I_n", 32'(I_n), 32'h7F);
        key_n = 8'hFF;
        steps(20);

        // Random key patterns, clears and occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            key_n = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
            dur = $urandom_range(30, 1);
            for (int k = 0; k < dur; k++) begin
                clr = ($urandom_range(15, 0) == 0);
                rst = ($urandom_range(127, 0) == 0);
                step();
            end
        end
        clr = 1'b0;
        rst = 1'b0;
        key_n = 8'hFF;
        steps(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
